fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter WIDTH, default 8, PC/address width; SHALL match the fetch stage width.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of cycles FlushDecode is held after a redirect; legal range 1..7.
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port BranchTaken  input  1  redirect request from execute.
REQ-006 Port BranchTarget  input  WIDTH  redirect target, valid when BranchTaken=1.
REQ-007 Port StallRequest  input  1  hazard-unit stall.
REQ-008 Port InstrReady  input  1  instruction memory can accept a fetch this cycle.
REQ-009 Port HaltRequest  input  1  halt instruction decoded.
REQ-010 Port FetchEnable  output  1  drives fetch-stage PC register enable.
REQ-011 Port PCSelector  output  1  1 = fetch stage loads NewPC, 0 = PC+1.
REQ-012 Port NewPC  output  WIDTH  redirect target to fetch stage.
REQ-013 Port FlushDecode  output  1  squash instruction in fetch/decode register.
REQ-014 Port Halted  output  1  controller is in HALTED.
REQ-015 Port FetchCount  output  16  count of PC updates since reset.

Function
REQ-016 FSM states SHALL be IDLE, RUN, WAIT, HALTED, held in one state register.
REQ-017 IDLE: entered by reset, lasts exactly one cycle, FetchEnable=0, then RUN unconditionally.
REQ-018 Blocked condition SHALL be StallRequest=1 or InstrReady=0.
REQ-019 RUN, not blocked, no pending redirect: FetchEnable=1, PCSelector=0.
REQ-020 RUN or WAIT, not blocked, BranchTaken=1: same cycle FetchEnable=1, PCSelector=1, NewPC=BranchTarget (combinational), pending cleared, next state RUN.
REQ-021 Blocked with BranchTaken=1: BranchTarget SHALL be captured into a pending-redirect register; next state WAIT; FetchEnable=0.
REQ-022 Second redirect while pending: latest target SHALL overwrite pending (latest wins).
REQ-023 WAIT, not blocked, pending set, BranchTaken=0: FetchEnable=1, PCSelector=1, NewPC=pending target, pending cleared, next state RUN.
REQ-024 RUN blocked without redirect: FetchEnable=0, next state WAIT; WAIT unblocked without pending behaves as REQ-019 and returns to RUN.
REQ-025 PCSelector SHALL be 1 only in cycles where FetchEnable=1; when PCSelector=0 NewPC SHALL be 0.
REQ-026 Every cycle with PCSelector=1 SHALL load a flush counter with FLUSH_CYCLES; FlushDecode=1 while counter nonzero, counter decrements by 1 per cycle, first FlushDecode cycle is the cycle after redirect.
REQ-027 Redirect during an active flush SHALL reload the counter (no accumulation).
REQ-028 HaltRequest=1 in RUN or WAIT with BranchTaken=0 and no pending redirect: next state HALTED; halt cycle FetchEnable=0.
REQ-029 HaltRequest with BranchTaken=1 or pending set: halt SHALL be ignored (wrong-path), redirect processed.
REQ-030 HALTED: FetchEnable=0, PCSelector=0, Halted=1, all inputs ignored; exit only via reset.
REQ-031 FetchCount SHALL increment by 1 each cycle FetchEnable=1, wrapping 0xFFFF→0x0000.

Reset
REQ-032 Reset SHALL override all inputs in the cycle sampled, including mid-redirect and HALTED.
REQ-033 After reset: state IDLE, pending cleared, flush counter 0, FetchCount 0, FetchEnable=0, PCSelector=0, NewPC=0, FlushDecode=0, Halted=0.

Structure
REQ-034 FSM state enum and FLUSH counter width constant SHALL live in shared package pipeline_ctrl_pkg.
REQ-035 Flush down-counter SHALL be sub-module flush_counter (load, decrement, nonzero flag); remainder in fetch_controller.
REQ-036 Outputs SHALL be combinational from registered state plus current-cycle inputs; no combinational path from NewPC to any input other than BranchTaken/BranchTarget/blocked inputs.

Verification
REQ-037 Reset, then 5 cycles InstrReady=1 -> cycle0 FetchEnable=0 (IDLE), cycles1-4 FetchEnable=1, FetchCount=4.
REQ-038 RUN, BranchTaken=1 BranchTarget=0x3C -> same cycle PCSelector=1 NewPC=0x3C; FlushDecode=1 next 2 cycles, then 0.
REQ-039 StallRequest=1 three cycles, BranchTaken with 0x10 then 0x20 during stall -> FetchEnable=0 throughout; release cycle NewPC=0x20, PCSelector=1.
REQ-040 HaltRequest=1 with BranchTaken=1 target 0x08 -> redirect to 0x08, no halt; next HaltRequest alone -> Halted=1, FetchEnable stays 0 for 10 cycles.
REQ-041 Reset asserted in HALTED and during pending redirect -> all outputs per REQ-033 next cycle, pending target not applied.
REQ-042 Force FetchCount to 0xFFFF then one fetch -> FetchCount=0x0000.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the fetch-side pipeline control logic.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  // Wide enough for the largest legal flush length (7).
  localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/flush_counter.sv
// Down-counter that keeps decode squashed for a fixed number of cycles
// after each redirect. A load during an active count restarts it.
module flush_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_VALUE = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_active
);

  logic [FLUSH_CNT_W-1:0] r_count;

  // Reload on redirect, otherwise count down to zero and stay there.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= FLUSH_CNT_W'(LOAD_VALUE);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_active = (r_count != '0);

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage controller: PC enable / redirect select, pending-redirect
// capture while blocked, decode flush after redirects, halt handling and
// a free-running count of PC updates.
module fetch_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             StallRequest,
  input  logic             InstrReady,
  input  logic             HaltRequest,
  output logic             FetchEnable,
  output logic             PCSelector,
  output logic [WIDTH-1:0] NewPC,
  output logic             FlushDecode,
  output logic             Halted,
  output logic [15:0]      FetchCount
);

  fetch_state_t     r_state;
  fetch_state_t     w_next_state;
  logic             r_pend_valid;
  logic [WIDTH-1:0] r_pend_target;
  logic [15:0]      r_fetch_count;
  logic             w_blocked;
  logic             w_pend_load;
  logic             w_pend_clear;

  assign w_blocked = StallRequest | ~InstrReady;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode. A live redirect beats a pending one,
  // and either suppresses a halt request (wrong-path instruction).
  always_comb begin
    w_next_state = r_state;
    FetchEnable  = 1'b0;
    PCSelector   = 1'b0;
    NewPC        = '0;
    w_pend_load  = 1'b0;
    w_pend_clear = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_next_state = ST_RUN;
      end
      ST_RUN, ST_WAIT: begin
        if (!w_blocked) begin
          w_next_state = ST_RUN;
          if (BranchTaken) begin
            FetchEnable  = 1'b1;
            PCSelector   = 1'b1;
            NewPC        = BranchTarget;
            w_pend_clear = 1'b1;
          end else if (r_pend_valid) begin
            FetchEnable  = 1'b1;
            PCSelector   = 1'b1;
            NewPC        = r_pend_target;
            w_pend_clear = 1'b1;
          end else if (HaltRequest) begin
            w_next_state = ST_HALTED;
          end else begin
            FetchEnable = 1'b1;
          end
        end else begin
          w_next_state = ST_WAIT;
          if (BranchTaken) begin
            w_pend_load = 1'b1;
          end else if (!r_pend_valid && HaltRequest) begin
            w_next_state = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        w_next_state = ST_HALTED;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Pending redirect: latest captured target wins until it is consumed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (w_pend_load) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= BranchTarget;
    end else if (w_pend_clear) begin
      r_pend_valid  <= 1'b0;
    end
  end

  // Count PC updates; wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_count <= '0;
    end else if (FetchEnable) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  flush_counter #(
    .LOAD_VALUE (FLUSH_CYCLES)
  ) u_flush_counter (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_load   (PCSelector),
    .o_active (FlushDecode)
  );

  assign Halted     = (r_state == ST_HALTED);
  assign FetchCount = r_fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a stimulus process drives one
// cycle at a time and queues the reference model's expected outputs; a
// monitor on the falling edge pops and compares.
module tb_fetch_controller;

  localparam int unsigned W  = 8;
  localparam int unsigned FC = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           BranchTaken = 1'b0;
  logic [W-1:0]   BranchTarget = '0;
  logic           StallRequest = 1'b0;
  logic           InstrReady = 1'b0;
  logic           HaltRequest = 1'b0;
  logic           FetchEnable;
  logic           PCSelector;
  logic [W-1:0]   NewPC;
  logic           FlushDecode;
  logic           Halted;
  logic [15:0]    FetchCount;

  fetch_controller #(
    .WIDTH        (W),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .StallRequest (StallRequest),
    .InstrReady   (InstrReady),
    .HaltRequest  (HaltRequest),
    .FetchEnable  (FetchEnable),
    .PCSelector   (PCSelector),
    .NewPC        (NewPC),
    .FlushDecode  (FlushDecode),
    .Halted       (Halted),
    .FetchCount   (FetchCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         fe;
    logic         sel;
    logic [W-1:0] pc;
    logic         flush;
    logic         halted;
    logic [15:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: "fresh" = first cycle after reset, plus halt flag,
  // pending redirect, remaining flush cycles and fetch count.
  bit           m_fresh  = 1'b1;
  bit           m_halted = 1'b0;
  bit           m_pend   = 1'b0;
  logic [W-1:0] m_ptgt   = '0;
  int           m_flush  = 0;
  logic [15:0]  m_cnt    = '0;

  task automatic step(input bit rst, input bit bt, input logic [W-1:0] tgt,
                      input bit stall, input bit ready, input bit halt);
    exp_t e;
    bit   blocked;
    @(posedge clock);
    #1;
    reset        = rst;
    BranchTaken  = bt;
    BranchTarget = tgt;
    StallRequest = stall;
    InstrReady   = ready;
    HaltRequest  = halt;
    if (rst) begin
      m_fresh  = 1'b1;
      m_halted = 1'b0;
      m_pend   = 1'b0;
      m_ptgt   = '0;
      m_flush  = 0;
      m_cnt    = '0;
    end else begin
      e.fe     = 1'b0;
      e.sel    = 1'b0;
      e.pc     = '0;
      e.flush  = (m_flush > 0);
      e.halted = m_halted;
      e.cnt    = m_cnt;
      blocked  = stall || !ready;
      if (m_halted) begin
        // nothing moves
      end else if (m_fresh) begin
        m_fresh = 1'b0;
      end else if (!blocked) begin
        if (bt) begin
          e.fe = 1'b1; e.sel = 1'b1; e.pc = tgt; m_pend = 1'b0;
        end else if (m_pend) begin
          e.fe = 1'b1; e.sel = 1'b1; e.pc = m_ptgt; m_pend = 1'b0;
        end else if (halt) begin
          m_halted = 1'b1;
        end else begin
          e.fe = 1'b1;
        end
      end else begin
        if (bt) begin
          m_pend = 1'b1; m_ptgt = tgt;
        end else if (!m_pend && halt) begin
          m_halted = 1'b1;
        end
      end
      if (e.sel) m_flush = FC;
      else if (m_flush > 0) m_flush = m_flush - 1;
      if (e.fe) m_cnt = m_cnt + 16'd1;
      q.push_back(e);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (FetchEnable !== e.fe || PCSelector !== e.sel || NewPC !== e.pc ||
          FlushDecode !== e.flush || Halted !== e.halted || FetchCount !== e.cnt) begin
        miscompares++;
        $display("FAIL vec%0d @%0t: got fe=%b sel=%b pc=%h flush=%b halted=%b cnt=%h, expected fe=%b sel=%b pc=%h flush=%b halted=%b cnt=%h",
                 vectors, $time, FetchEnable, PCSelector, NewPC, FlushDecode, Halted, FetchCount,
                 e.fe, e.sel, e.pc, e.flush, e.halted, e.cnt);
      end
    end
  end

  initial begin
    int guard;
    // Reset then free fetching.
    step(1, 0, '0, 0, 1, 0);
    repeat (5) step(0, 0, '0, 0, 1, 0);
    // Unblocked redirect, then flush window.
    step(0, 1, 8'h3C, 0, 1, 0);
    repeat (3) step(0, 0, '0, 0, 1, 0);
    // Two redirects during a stall: latest wins on release.
    step(0, 1, 8'h10, 1, 1, 0);
    step(0, 1, 8'h20, 1, 1, 0);
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 0, 1, 0);
    repeat (3) step(0, 0, '0, 0, 1, 0);
    // Instruction memory not ready blocks too.
    step(0, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 1, 0);
    // Halt on the wrong path is ignored; a lone halt sticks.
    step(0, 1, 8'h08, 0, 1, 1);
    step(0, 0, '0, 0, 1, 1);
    repeat (10) step(0, $urandom_range(0, 1), 8'($urandom), 0, 1, $urandom_range(0, 1));
    // Reset from HALTED.
    step(1, 1, 8'h77, 0, 1, 1);
    repeat (3) step(0, 0, '0, 0, 1, 0);
    // Reset while a redirect is pending: target must be dropped.
    step(0, 1, 8'h55, 1, 1, 0);
    step(1, 0, '0, 1, 1, 0);
    repeat (4) step(0, 0, '0, 0, 1, 0);
    // Halt requested while blocked with a pending redirect is ignored.
    step(0, 1, 8'hA5, 1, 1, 0);
    step(0, 0, '0, 1, 1, 1);
    step(0, 0, '0, 0, 1, 0);
    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 4) == 0,
           8'($urandom),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) != 0,
           $urandom_range(0, 49) == 0);
    end
    // Counter wrap: free-run from reset to 0xFFFF, then one more fetch.
    step(1, 0, '0, 0, 1, 0);
    step(0, 0, '0, 0, 1, 0);
    while (m_cnt != 16'hFFFF) step(0, 0, '0, 0, 1, 0);
    step(0, 0, '0, 0, 1, 0);
    step(0, 0, '0, 1, 1, 0);
    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
